// File: rtl/tinyriscv_div_unit.sv
// rtl/tinyriscv_div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, BITS_PER_CYCLE quotient bits per cycle
// Optional TINYRISCV_DIV_EARLY_OUT_EN: skip CALC when |dividend| < |divisor|.
module tinyriscv_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int WADDR_W        = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic [WADDR_W-1:0] reg_waddr_i,
    input  logic               abort_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [WADDR_W-1:0] reg_waddr_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [CNT_W-1:0]   r_cnt;
    logic [WADDR_W-1:0] r_waddr;
    logic [WIDTH-1:0]   r_result;
    logic [WADDR_W-1:0] r_waddr_out;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_early;
    logic [WIDTH:0]     w_step_r_x;
    logic [WIDTH-1:0]   w_step_q;
    logic [WIDTH-1:0]   w_step_r;
    logic [WIDTH-1:0]   w_final;

    assign w_accept   = (r_state == S_IDLE) && start_i && !abort_i && op_i[2];
    assign w_signed   = ~r_op[0];
    // In START, r_quot/r_divisor still hold the raw operands captured in IDLE.
    assign w_a_neg    = w_signed & r_quot[WIDTH-1];
    assign w_b_neg    = w_signed & r_divisor[WIDTH-1];
    assign w_abs_a    = w_a_neg ? -r_quot : r_quot;
    assign w_abs_b    = w_b_neg ? -r_divisor : r_divisor;
    assign w_div_zero = (r_divisor == '0);
    assign w_overflow = w_signed && (r_quot == {1'b1, {(WIDTH-1){1'b0}}}) && (r_divisor == '1);
`ifdef TINYRISCV_DIV_EARLY_OUT_EN
    assign w_early    = (w_abs_a < w_abs_b);
`else
    assign w_early    = 1'b0;
`endif

    // Restoring shift-subtract: dividend bits shift out of r_quot into the partial remainder.
    always_comb begin
        w_step_r_x = {1'b0, r_rem};
        w_step_q   = r_quot;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_step_r_x = {w_step_r_x[WIDTH-1:0], w_step_q[WIDTH-1]};
            w_step_q   = {w_step_q[WIDTH-2:0], 1'b0};
            if (w_step_r_x >= {1'b0, r_divisor}) begin
                w_step_r_x  = w_step_r_x - {1'b0, r_divisor};
                w_step_q[0] = 1'b1;
            end
        end
    end
    assign w_step_r = w_step_r_x[WIDTH-1:0];

    assign w_final = r_op[1] ? (r_neg_r ? -r_rem : r_rem)
                             : (r_neg_q ? -r_quot : r_quot);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_START;
            S_START: begin
                if (abort_i)                                 w_next = S_IDLE;
                else if (w_div_zero || w_overflow || w_early) w_next = S_END;
                else                                         w_next = S_CALC;
            end
            S_CALC: begin
                if (abort_i)                 w_next = S_IDLE;
                else if (r_cnt == LAST_CNT)  w_next = S_END;
            end
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_result    <= '0;
            r_waddr_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op_i[1:0];
                        r_quot    <= dividend_i;
                        r_divisor <= divisor_i;
                        r_waddr   <= reg_waddr_i;
                    end
                end
                S_START: begin
                    r_cnt     <= '0;
                    r_divisor <= w_abs_b;
                    if (w_div_zero) begin
                        r_quot  <= '1;
                        r_rem   <= r_quot;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_overflow) begin
                        r_rem   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_early) begin
                        r_quot  <= '0;
                        r_rem   <= r_quot;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_quot  <= w_abs_a;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                S_CALC: begin
                    r_quot <= w_step_q;
                    r_rem  <= w_step_r;
                    if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
                end
                S_END: begin
                    r_result    <= w_final;
                    r_waddr_out <= r_waddr;
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign ready_o     = (r_state == S_END);
    assign result_o    = ready_o ? w_final : r_result;
    assign reg_waddr_o = ready_o ? r_waddr : r_waddr_out;

endmodule

// File: tb/tb_tinyriscv_div_unit.sv
// tb/tb_tinyriscv_div_unit.sv - scoreboard bench for tinyriscv_div_unit (32/1 and 16/4 instances)
module tb_tinyriscv_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_ready_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_start = 0, a_abort = 0;
    logic [2:0]  a_op = 3'b101;
    logic [31:0] a_dvd = 0, a_dvs = 0;
    logic [4:0]  a_wa = 0;
    logic [31:0] a_res;
    logic [4:0]  a_wao;
    logic        a_ready, a_busy;

    logic        b_start = 0, b_abort = 0;
    logic [2:0]  b_op = 3'b101;
    logic [15:0] b_dvd = 0, b_dvs = 0;
    logic [4:0]  b_wa = 0;
    logic [15:0] b_res;
    logic [4:0]  b_wao;
    logic        b_ready, b_busy;

    tinyriscv_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .WADDR_W(5)) u_a (
        .clk(clk), .rst(rst), .start_i(a_start), .op_i(a_op),
        .dividend_i(a_dvd), .divisor_i(a_dvs), .reg_waddr_i(a_wa), .abort_i(a_abort),
        .result_o(a_res), .reg_waddr_o(a_wao), .ready_o(a_ready), .busy_o(a_busy)
    );

    tinyriscv_div_unit #(.WIDTH(16), .BITS_PER_CYCLE(4), .WADDR_W(5)) u_b (
        .clk(clk), .rst(rst), .start_i(b_start), .op_i(b_op),
        .dividend_i(b_dvd), .divisor_i(b_dvs), .reg_waddr_i(b_wa), .abort_i(b_abort),
        .result_o(b_res), .reg_waddr_o(b_wao), .ready_o(b_ready), .busy_o(b_busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (op)
            3'b100:  r = (y == 0) ? 32'hFFFF_FFFF : ((x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy));
            3'b101:  r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110:  r = (y == 0) ? x : ((x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(sx % sy));
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, ay;
        ax = (!op[0] && x[31]) ? -x : x;
        ay = (!op[0] && y[31]) ? -y : y;
        if (y == 0) return 2;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef TINYRISCV_DIV_EARLY_OUT_EN
        if (ax < ay) return 2;
`endif
        return 34;
    endfunction

    task automatic run_op(input bit use_b, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] wa, input logic [31:0] exp_res, input int exp_lat, input string name);
        exp_t e;
        int   lat;
        int   g;
        bit   got;
        logic [31:0] res;
        logic [4:0]  wao;
        g = 0;
        @(negedge clk);
        while ((use_b ? b_busy : a_busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (use_b) begin
            b_op = op; b_dvd = x[15:0]; b_dvs = y[15:0]; b_wa = wa; b_start = 1;
        end else begin
            a_op = op; a_dvd = x; a_dvs = y; a_wa = wa; a_start = 1;
        end
        e.res = exp_res;
        e.wa  = wa;
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        a_start = 0;
        b_start = 0;
        lat = 1;
        got = use_b ? b_ready : a_ready;
        while (!got && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            got = use_b ? b_ready : a_ready;
        end
        res = use_b ? {16'h0, b_res} : a_res;
        wao = use_b ? b_wao : a_wao;
        e = sb_q.pop_front();
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s timeout: no ready_o within %0d cycles", name, lat);
        end else begin
            last_ready_cyc = cyc;
            if (res !== e.res) begin
                n_errors++;
                $display("FAIL %s result got %h want %h", name, res, e.res);
            end
            n_checks++;
            if (wao !== e.wa) begin
                n_errors++;
                $display("FAIL %s reg_waddr got %0d want %0d", name, wao, e.wa);
            end
            n_checks++;
            if (lat != e.lat) begin
                n_errors++;
                $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
            end
        end
    endtask

    task automatic watch_no_ready(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (a_ready || b_ready) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL %s ready pulses got %0d want 0", name, seen);
        end
    endtask

    task automatic test_reset();
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_busy, a_ready, b_busy, b_ready} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 0000", {a_busy, a_ready, b_busy, b_ready});
        end
        n_checks++;
        if (a_res !== 32'h0 || b_res !== 16'h0 || a_wao !== 5'd0 || b_wao !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h/%h/%0d/%0d want 0", a_res, b_res, a_wao, b_wao);
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_unsigned();
        run_op(0, 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 34, "divu_100_7");
        run_op(0, 3'b111, 32'd100, 32'd7, 5'd5, 32'd2, 34, "remu_100_7");
    endtask

    task automatic test_signed();
        run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(0, 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 34, "div_7_m2");
    endtask

    task automatic test_special();
        run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 2, "div_overflow");
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0, 2, "rem_overflow");
        run_op(0, 3'b101, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 2, "divu_by_zero");
        run_op(0, 3'b111, 32'd5, 32'd0, 5'd4, 32'd5, 2, "remu_by_zero");
    endtask

    task automatic test_abort();
        int lat;
        @(negedge clk);
        a_op = 3'b101; a_dvd = 32'd1000; a_dvs = 32'd3; a_wa = 5'd9; a_start = 1;
        @(posedge clk);
        #1;
        a_start = 0;
        lat = 1;
        while (lat < 11) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        a_abort = 1;
        @(posedge clk);
        #1;
        a_abort = 0;
        n_checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle busy/ready got %b%b want 00", a_busy, a_ready);
        end
        n_checks++;
        if (a_res !== 32'd5 || a_wao !== 5'd4) begin
            n_errors++;
            $display("FAIL abort_hold result/waddr got %h/%0d want 00000005/4", a_res, a_wao);
        end
        watch_no_ready(40, "abort_no_ready");
        @(negedge clk);
        a_op = 3'b101; a_dvd = 32'd9; a_dvs = 32'd3; a_start = 1; a_abort = 1;
        @(posedge clk);
        #1;
        a_start = 0;
        a_abort = 0;
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_with_abort busy got %b want 0", a_busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_op = 3'b101; a_dvd = 32'd100; a_dvs = 32'd7; a_wa = 5'd5; a_start = 1;
        @(posedge clk);
        #1;
        a_start = 0;
        repeat (5) @(posedge clk);
        #3;
        rst = 0;
        #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_res !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid got busy %b ready %b result %h want 0 0 0", a_busy, a_ready, a_res);
        end
        @(negedge clk);
        rst = 1;
        watch_no_ready(40, "reset_mid_no_ready");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            x  = $urandom;
            y  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) y = 0;
            run_op(0, op, x, y, 5'(i + 10), model_res(op, x, y), model_lat(op, x, y), "random");
        end
    endtask

    task automatic test_sweep_16_4();
        run_op(1, 3'b101, 32'hFFFF, 32'd3, 5'd3, 32'h5555, 6, "w16_divu_ffff_3");
        run_op(1, 3'b100, 32'h8000, 32'hFFFF, 5'd4, 32'h8000, 2, "w16_div_overflow");
    endtask

    task automatic test_back_to_back();
        int c1;
        run_op(1, 3'b101, 32'd1000, 32'd7, 5'd11, 32'd142, 6, "b2b_first");
        c1 = last_ready_cyc;
        run_op(1, 3'b111, 32'd1000, 32'd7, 5'd12, 32'd6, 6, "b2b_second");
        n_checks++;
        if (last_ready_cyc - c1 != 7) begin
            n_errors++;
            $display("FAIL b2b_spacing got %0d want 7", last_ready_cyc - c1);
        end
    endtask

    task automatic test_early_out();
`ifdef TINYRISCV_DIV_EARLY_OUT_EN
        run_op(1, 3'b101, 32'd3, 32'd9, 5'd13, 32'd0, 2, "early_divu_3_9");
        run_op(1, 3'b110, 32'hFFFD, 32'd9, 5'd14, 32'hFFFD, 2, "early_rem_m3_9");
`else
        run_op(1, 3'b101, 32'd3, 32'd9, 5'd13, 32'd0, 6, "early_divu_3_9");
        run_op(1, 3'b110, 32'hFFFD, 32'd9, 5'd14, 32'hFFFD, 6, "early_rem_m3_9");
`endif
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_abort();
        test_random();
        test_sweep_16_4();
        test_back_to_back();
        test_early_out();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
